// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exc_pkg
// Purpose  : Shared definitions for the exception controller.
//            Holds the FSM state encoding, the MIPS ExcCode values,
//            the CP0 Status/Cause bit positions and the default vector offset.
// Revision : 1.0 - initial release
// ============================================================================
package exc_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_ERET  = 2'd2
  } exc_state_t;

  // ExcCode values written into Cause[6:2]
  localparam logic [4:0] c_EXC_INT  = 5'd0;
  localparam logic [4:0] c_EXC_ADEL = 5'd4;
  localparam logic [4:0] c_EXC_ADES = 5'd5;
  localparam logic [4:0] c_EXC_SYS  = 5'd8;
  localparam logic [4:0] c_EXC_BP   = 5'd9;
  localparam logic [4:0] c_EXC_RI   = 5'd10;
  localparam logic [4:0] c_EXC_OV   = 5'd12;

  // Status register bit positions
  localparam int c_ST_IE    = 0;
  localparam int c_ST_EXL   = 1;
  localparam int c_ST_IM_HI = 15;
  localparam int c_ST_IM_LO = 8;

  // Cause register bit positions
  localparam int c_CAUSE_BD     = 31;
  localparam int c_CAUSE_IP_HI  = 15;
  localparam int c_CAUSE_IP_LO  = 8;
  localparam int c_CAUSE_SW_HI  = 9;
  localparam int c_CAUSE_SW_LO  = 8;
  localparam int c_CAUSE_EXC_HI = 6;
  localparam int c_CAUSE_EXC_LO = 2;

  // Status.EXL as a mask for set/clear operations
  localparam logic [31:0] c_STATUS_EXL_MASK = 32'h0000_0002;

  // General exception vector offset from EBase
  localparam logic [11:0] c_VEC_OFFSET_DEFAULT = 12'h180;

  // EPC value: a delay-slot instruction restarts at its branch
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exc_int_pending.sv
`default_nettype none
// ============================================================================
// Module   : exc_int_pending
// Purpose  : Sticky timer-interrupt latch plus the pending-interrupt vector
//            and the qualified interrupt request seen at commit.
// Revision : 1.0 - initial release
// ============================================================================
module exc_int_pending
  import exc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clock_int,
  input  logic       i_take_int,
  input  logic       i_commit_valid,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [4:0] i_hw_int,
  input  logic [1:0] i_sw_ip,
  input  logic [7:0] i_im,
  output logic [7:0] o_ip,
  output logic       o_int_req
);

  logic r_timer_pend;

  // Timer pulse is remembered until an interrupt is actually taken;
  // a pulse arriving in the same cycle as the take survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer_pend <= 1'b0;
    end else begin
      r_timer_pend <= i_clock_int | (r_timer_pend & ~i_take_int);
    end
  end

  assign o_ip      = {r_timer_pend, i_hw_int, i_sw_ip};
  assign o_int_req = i_commit_valid & i_ie & ~i_exl & (|(o_ip & i_im));

endmodule
`default_nettype wire

// File: rtl/exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exception_ctrl
// Purpose  : Commit-stage exception/interrupt/ERET controller. Arbitrates the
//            events, captures the faulting context and issues CP0 writes,
//            pipeline flush and fetch redirect for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module exception_ctrl
  import exc_pkg::*;
#(
  parameter logic [11:0] VEC_OFFSET = c_VEC_OFFSET_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        commitValid,
  input  logic [31:0] commitPc,
  input  logic        commitInDelaySlot,
  input  logic        excValid,
  input  logic [4:0]  excCode,
  input  logic        excBadAddrValid,
  input  logic [31:0] excBadAddr,
  input  logic        eretValid,
  input  logic        clockInterrupt,
  input  logic [4:0]  hwInterrupt,
  input  logic [31:0] status12In,
  input  logic [31:0] cause13In,
  input  logic [31:0] epc14In,
  input  logic [31:0] ebase15In,
  output logic        write8,
  output logic        write12,
  output logic        write13,
  output logic        write14,
  output logic [31:0] write8data,
  output logic [31:0] write12data,
  output logic [31:0] write13data,
  output logic [31:0] write14data,
  output logic        flush,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  output logic        busy
);

  exc_state_t  r_state;
  exc_state_t  w_state_nxt;

  // Context captured when an event is accepted
  logic [4:0]  r_code;
  logic [31:0] r_pc;
  logic        r_bd;
  logic        r_bad_valid;
  logic [31:0] r_bad_addr;
  logic        r_exl;
  logic [7:0]  r_ip;

  logic [7:0]  w_ip;
  logic        w_int_req;
  logic        w_idle_go;
  logic        w_take_exc;
  logic        w_take_int;
  logic        w_take_eret;
  logic [31:0] w_cause_new;

  exc_int_pending u_int_pending (
    .clk            (clock),
    .rst            (reset),
    .i_clock_int    (clockInterrupt),
    .i_take_int     (w_take_int),
    .i_commit_valid (commitValid),
    .i_ie           (status12In[c_ST_IE]),
    .i_exl          (status12In[c_ST_EXL]),
    .i_hw_int       (hwInterrupt),
    .i_sw_ip        (cause13In[c_CAUSE_SW_HI:c_CAUSE_SW_LO]),
    .i_im           (status12In[c_ST_IM_HI:c_ST_IM_LO]),
    .o_ip           (w_ip),
    .o_int_req      (w_int_req)
  );

  // Fixed priority: synchronous exception, then interrupt, then ERET
  assign w_idle_go   = (r_state == ST_IDLE) & ready;
  assign w_take_exc  = w_idle_go & excValid;
  assign w_take_int  = w_idle_go & ~excValid & w_int_req;
  assign w_take_eret = w_idle_go & ~excValid & ~w_int_req & eretValid;

  assign busy = (r_state != ST_IDLE);

  // State register; reset aborts any entry/return in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the committing instruction's context on exception/interrupt accept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_code      <= 5'd0;
      r_pc        <= 32'd0;
      r_bd        <= 1'b0;
      r_bad_valid <= 1'b0;
      r_bad_addr  <= 32'd0;
      r_exl       <= 1'b0;
      r_ip        <= 8'd0;
    end else if (w_take_exc) begin
      r_code      <= excCode;
      r_pc        <= commitPc;
      r_bd        <= commitInDelaySlot;
      r_bad_valid <= excBadAddrValid;
      r_bad_addr  <= excBadAddr;
      r_exl       <= status12In[c_ST_EXL];
      r_ip        <= w_ip;
    end else if (w_take_int) begin
      r_code      <= c_EXC_INT;
      r_pc        <= commitPc;
      r_bd        <= commitInDelaySlot;
      r_bad_valid <= 1'b0;
      r_bad_addr  <= 32'd0;
      r_exl       <= status12In[c_ST_EXL];
      r_ip        <= w_ip;
    end
  end

  // New Cause value: code and pending bits always, BD only on first-level entry
  always_comb begin
    w_cause_new = cause13In;
    w_cause_new[c_CAUSE_EXC_HI:c_CAUSE_EXC_LO] = r_code;
    w_cause_new[c_CAUSE_IP_HI:c_CAUSE_IP_LO]   = r_ip;
    if (!r_exl) begin
      w_cause_new[c_CAUSE_BD] = r_bd;
    end
  end

  // Next-state and output decode; all strobes come straight from state
  always_comb begin
    w_state_nxt   = r_state;
    write8        = 1'b0;
    write12       = 1'b0;
    write13       = 1'b0;
    write14       = 1'b0;
    write8data    = 32'd0;
    write12data   = 32'd0;
    write13data   = 32'd0;
    write14data   = 32'd0;
    flush         = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_take_exc || w_take_int) begin
          w_state_nxt = ST_ENTER;
        end else if (w_take_eret) begin
          w_state_nxt = ST_ERET;
        end
      end
      ST_ENTER: begin
        write13       = 1'b1;
        write13data   = w_cause_new;
        write14       = ~r_exl;
        write14data   = r_exl ? 32'd0 : epc_of(r_pc, r_bd);
        write12       = 1'b1;
        write12data   = status12In | c_STATUS_EXL_MASK;
        write8        = r_bad_valid;
        write8data    = r_bad_valid ? r_bad_addr : 32'd0;
        flush         = 1'b1;
        redirectValid = 1'b1;
        redirectPc    = {ebase15In[31:12], VEC_OFFSET};
        if (ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERET: begin
        write12       = 1'b1;
        write12data   = status12In & ~c_STATUS_EXL_MASK;
        flush         = 1'b1;
        redirectValid = 1'b1;
        redirectPc    = epc14In;
        if (ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exception_ctrl
// Purpose  : Scoreboard bench for exception_ctrl: directed scenarios followed
//            by random traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exception_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ready;
  logic        commitValid;
  logic [31:0] commitPc;
  logic        commitInDelaySlot;
  logic        excValid;
  logic [4:0]  excCode;
  logic        excBadAddrValid;
  logic [31:0] excBadAddr;
  logic        eretValid;
  logic        clockInterrupt;
  logic [4:0]  hwInterrupt;
  logic [31:0] status12In, cause13In, epc14In, ebase15In;
  logic        write8, write12, write13, write14;
  logic [31:0] write8data, write12data, write13data, write14data;
  logic        flush, redirectValid, busy;
  logic [31:0] redirectPc;

  exception_ctrl #(.VEC_OFFSET(12'h180)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .commitValid(commitValid), .commitPc(commitPc), .commitInDelaySlot(commitInDelaySlot),
    .excValid(excValid), .excCode(excCode),
    .excBadAddrValid(excBadAddrValid), .excBadAddr(excBadAddr),
    .eretValid(eretValid), .clockInterrupt(clockInterrupt), .hwInterrupt(hwInterrupt),
    .status12In(status12In), .cause13In(cause13In), .epc14In(epc14In), .ebase15In(ebase15In),
    .write8(write8), .write12(write12), .write13(write13), .write14(write14),
    .write8data(write8data), .write12data(write12data),
    .write13data(write13data), .write14data(write14data),
    .flush(flush), .redirectValid(redirectValid), .redirectPc(redirectPc), .busy(busy)
  );

  always #5 clock = ~clock;

  // One expected CP0 update, described by the event that caused it
  typedef struct {
    bit          eret;
    logic [4:0]  code;
    logic [31:0] pc;
    bit          bd;
    bit          bad_v;
    logic [31:0] bad;
    bit          exl;
    logic [7:0]  ip;
  } txn_t;

  txn_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   m_busy  = 1'b0;   // model: an update is outstanding
  bit   m_timer = 1'b0;   // model: timer interrupt pending

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: decide what the upcoming clock edge should accept
  task automatic model_step();
    logic [7:0] ip;
    bit         ireq;
    txn_t       t;
    ip   = {m_timer, hwInterrupt, cause13In[9:8]};
    ireq = commitValid && status12In[0] && !status12In[1] && ((ip & status12In[15:8]) != 8'd0);
    t    = '{default: '0};
    if (ready) begin
      if (m_busy) begin
        m_busy = 1'b0;
      end else if (excValid) begin
        t.code = excCode; t.pc = commitPc; t.bd = commitInDelaySlot;
        t.bad_v = excBadAddrValid; t.bad = excBadAddr;
        t.exl = status12In[1]; t.ip = ip;
        sb_q.push_back(t);
        m_busy = 1'b1;
      end else if (ireq) begin
        t.code = 5'd0; t.pc = commitPc; t.bd = commitInDelaySlot;
        t.exl = status12In[1]; t.ip = ip;
        sb_q.push_back(t);
        m_busy  = 1'b1;
        m_timer = 1'b0;
      end else if (eretValid) begin
        t.eret = 1'b1;
        sb_q.push_back(t);
        m_busy = 1'b1;
      end
    end
    if (clockInterrupt) m_timer = 1'b1;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    ready = 1'b1; commitValid = 1'b0; commitInDelaySlot = 1'b0;
    excValid = 1'b0; excCode = 5'd0; excBadAddrValid = 1'b0; excBadAddr = 32'd0;
    eretValid = 1'b0; clockInterrupt = 1'b0; hwInterrupt = 5'd0;
  endtask

  // Monitor: each completing ENTER/ERET cycle consumes one scoreboard entry
  always @(negedge clock) begin : mon
    txn_t        t;
    logic [31:0] exp_c;
    if (!reset && ready && (busy || flush)) begin
      if (sb_q.size() == 0) begin
        check("spurious_update", 32'(flush), 32'd0);
      end else begin
        t = sb_q.pop_front();
        if (t.eret) begin
          check("eret_strobes", {26'd0, write8, write12, write13, write14, flush, redirectValid},
                32'b010011);
          check("eret_w12d", write12data, status12In & ~32'h2);
          check("eret_rpc", redirectPc, epc14In);
        end else begin
          exp_c = cause13In;
          exp_c[6:2]  = t.code;
          exp_c[15:8] = t.ip;
          if (!t.exl) exp_c[31] = t.bd;
          check("enter_strobes", {26'd0, write8, write12, write13, write14, flush, redirectValid},
                {26'd0, t.bad_v, 1'b1, 1'b1, !t.exl, 1'b1, 1'b1});
          check("enter_w13d", write13data, exp_c);
          if (!t.exl) check("enter_w14d", write14data, t.bd ? (t.pc - 32'd4) : t.pc);
          check("enter_w12d", write12data, status12In | 32'h2);
          if (t.bad_v) check("enter_w8d", write8data, t.bad);
          check("enter_rpc", redirectPc, {ebase15In[31:12], 12'h180});
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : drv
    logic [31:0] rnd;
    logic [4:0]  codes [7];
    codes = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13};

    clr();
    reset = 1'b1;
    commitPc = 32'd0; status12In = 32'd0; cause13In = 32'd0;
    epc14In = 32'd0; ebase15In = 32'h8000_0000;
    repeat (2) @(posedge clock);
    #1;
    check("rst_strobes", {25'd0, write8, write12, write13, write14, flush, redirectValid, busy}, 32'd0);
    check("rst_data", write8data | write12data | write13data | write14data | redirectPc, 32'd0);
    reset = 1'b0;
    cyc();

    // SYSCALL, not in delay slot
    excValid = 1'b1; excCode = 5'd8; commitValid = 1'b1; commitPc = 32'h8000_1000;
    status12In = 32'h0000_0001; ebase15In = 32'h8000_0000;
    cyc();
    check("sys_code", 32'(write13data[6:2]), 32'd8);
    check("sys_epc", write14data, 32'h8000_1000);
    check("sys_status", write12data, 32'h0000_0003);
    check("sys_rpc", redirectPc, 32'h8000_0180);
    check("sys_flush", 32'(flush), 32'd1);
    clr();
    cyc();
    check("sys_back_idle", 32'(busy), 32'd0);

    // AdEL in a delay slot with a bad address
    excValid = 1'b1; excCode = 5'd4; commitValid = 1'b1; commitPc = 32'h8000_2004;
    commitInDelaySlot = 1'b1; excBadAddrValid = 1'b1; excBadAddr = 32'h1;
    cyc();
    check("adel_epc", write14data, 32'h8000_2000);
    check("adel_bd", 32'(write13data[31]), 32'd1);
    check("adel_w8", {31'd0, write8}, 32'd1);
    check("adel_w8d", write8data, 32'h1);
    clr();
    cyc();

    // Timer interrupt taken, then the pending bit is gone
    status12In = 32'h0000_8001; commitValid = 1'b1; clockInterrupt = 1'b1;
    cyc();
    clockInterrupt = 1'b0;
    cyc();
    check("tmr_enter", 32'(busy), 32'd1);
    check("tmr_code", 32'(write13data[6:2]), 32'd0);
    check("tmr_ip7", 32'(write13data[15]), 32'd1);
    cyc();
    cyc();
    cyc();
    check("tmr_cleared", 32'(busy), 32'd0);

    // Timer under EXL: no entry, pending survives until EXL drops
    status12In = 32'h0000_8003; clockInterrupt = 1'b1;
    cyc();
    clockInterrupt = 1'b0;
    repeat (3) cyc();
    check("tmr_exl_block", 32'(busy), 32'd0);
    status12In = 32'h0000_8001;
    cyc();
    check("tmr_kept", 32'(write13data[15]), 32'd1);
    cyc();
    commitValid = 1'b0;
    cyc();

    // Exception, interrupt and ERET together; second exception during ENTER
    status12In = 32'h0000_0401; hwInterrupt = 5'd1; commitValid = 1'b1;
    excValid = 1'b1; excCode = 5'd12; eretValid = 1'b1; commitPc = 32'h8000_4000;
    cyc();
    check("prio_code", 32'(write13data[6:2]), 32'd12);
    excCode = 5'd10;
    cyc();
    excValid = 1'b0; eretValid = 1'b0; hwInterrupt = 5'd0;
    check("prio_single", 32'(busy), 32'd0);
    cyc();

    // ERET
    clr();
    eretValid = 1'b1; epc14In = 32'h8000_3000; status12In = 32'h0000_0003;
    cyc();
    check("eret_status", write12data, 32'h0000_0001);
    check("eret_target", redirectPc, 32'h8000_3000);
    clr();
    cyc();

    // Stall three cycles inside ENTER
    status12In = 32'h0000_0001; ebase15In = 32'h9000_0000;
    excValid = 1'b1; excCode = 5'd10; commitValid = 1'b1; commitPc = 32'h8000_5000;
    cyc();
    clr();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_hold", {30'd0, busy, flush}, 32'd3);
      check("stall_rpc", redirectPc, 32'h9000_0180);
    end
    ready = 1'b1;
    cyc();
    check("stall_release", 32'(busy), 32'd0);

    // Reset in the middle of ENTER
    excValid = 1'b1; excCode = 5'd9; commitValid = 1'b1;
    cyc();
    clr();
    #2;
    reset = 1'b1;
    sb_q.delete();
    m_busy = 1'b0; m_timer = 1'b0;
    #1;
    check("rstmid_outs", {25'd0, write8, write12, write13, write14, flush, redirectValid, busy}, 32'd0);
    check("rstmid_data", write8data | write12data | write13data | write14data | redirectPc, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc();
    check("rstmid_idle", {30'd0, busy, flush}, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      ready             = ($urandom_range(0, 3) != 0);
      commitValid       = ($urandom_range(0, 3) != 0);
      excValid          = ($urandom_range(0, 7) == 0);
      excCode           = codes[$urandom_range(0, 6)];
      rnd               = $urandom;
      commitPc          = {rnd[31:2], 2'b00};
      commitInDelaySlot = $urandom_range(0, 1) != 0;
      excBadAddrValid   = $urandom_range(0, 1) != 0;
      excBadAddr        = $urandom;
      eretValid         = ($urandom_range(0, 7) == 0);
      clockInterrupt    = ($urandom_range(0, 15) == 0);
      rnd               = $urandom;
      hwInterrupt       = ($urandom_range(0, 3) == 0) ? rnd[4:0] : 5'd0;
      rnd               = $urandom;
      status12In        = {16'd0, rnd[15:8], 6'd0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0)};
      cause13In         = $urandom;
      epc14In           = $urandom;
      ebase15In         = $urandom;
      cyc();
    end

    clr();
    repeat (4) cyc();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter VEC_OFFSET, default 12'h180, meaning the general exception vector offset added to EBase.
REQ-002 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ready  in  1  pipeline-advance enable; all state holds when 0.
REQ-005 SHALL have port commitValid  in  1  an instruction is at commit; commitPc is valid.
REQ-006 SHALL have ports commitPc in 32 and commitInDelaySlot in 1, giving the committing instruction's PC and branch-delay-slot flag.
REQ-007 SHALL have ports excValid in 1 and excCode in 5, giving a synchronous exception at commit and its ExcCode.
REQ-008 SHALL have ports excBadAddrValid in 1 and excBadAddr in 32, giving the faulting address for AdEL/AdES/TLB exceptions.
REQ-009 SHALL have port eretValid  in  1  ERET at commit.
REQ-010 SHALL have ports clockInterrupt in 1 (single-cycle timer pulse from the CP0 register file) and hwInterrupt in 5 (level-sensitive external lines).
REQ-011 SHALL have ports status12In, cause13In, epc14In, ebase15In, each in 32, carrying forwarded CP0 register values.
REQ-012 SHALL have CP0 write ports write8, write12, write13, write14 (out 1 each) and write8data, write12data, write13data, write14data (out 32 each).
REQ-013 SHALL have port flush  out  1  kill all younger pipeline stages.
REQ-014 SHALL have ports redirectValid out 1 and redirectPc out 32, giving a fetch redirect.
REQ-015 SHALL have port busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 SHALL latch the clockInterrupt pulse into sticky bit timerPend, which clears only on entry to an interrupt exception or on reset.
REQ-017 SHALL form ip[7:0] = {timerPend, hwInterrupt[4:0], cause13In[9:8]}.
REQ-018 SHALL raise intReq = commitValid & status[0] (IE) & ~status[1] (EXL) & |(ip & status[15:8]).
REQ-019 SHALL accept events only in IDLE with ready=1, with priority excValid > intReq > eretValid; lower-priority simultaneous events are dropped.
REQ-020 SHALL implement FSM states IDLE, ENTER and ERET. An accepted exception or interrupt moves IDLE to ENTER; an accepted ERET moves IDLE to ERET; ENTER and ERET each return to IDLE after exactly one ready=1 cycle.
REQ-021 SHALL register the captured code (0 for an interrupt), PC, BD flag, badaddr and EXL-at-accept on acceptance.
REQ-022 SHALL, in ENTER, assert write13 with data equal to cause13In, with [6:2]=code, [15:8]=ip, and [31]=BD only if the captured EXL was 0 (otherwise the old [31] is kept).
REQ-023 SHALL, in ENTER, assert write14=1 with data equal to the captured PC when BD=0 or the captured PC-4 when BD=1 (mod 2^32), only if the captured EXL was 0.
REQ-024 SHALL, in ENTER, assert write12 with data status12In | 32'h2.
REQ-025 SHALL, in ENTER, assert write8 only when the captured excBadAddrValid was 1.
REQ-026 SHALL, in ENTER, assert flush=1, redirectValid=1 and redirectPc={ebase15In[31:12], VEC_OFFSET}.
REQ-027 SHALL, in ERET, assert write12 with data status12In & ~32'h2, plus flush=1, redirectValid=1 and redirectPc=epc14In.
REQ-028 SHALL hold state, outputs and captured registers unchanged while ready=0 in any state; timerPend still sets.
REQ-029 SHALL ignore requests arriving in ENTER or ERET (the pipeline is being flushed).
REQ-030 SHALL drive every strobe and datum combinationally from state and captured registers, so the CP0 write lands at the end of the ENTER/ERET cycle.

Reset
REQ-031 SHALL, on reset, force state to IDLE asynchronously and clear timerPend and all captured registers; all outputs read 0 while in reset.
REQ-032 SHALL abort an ENTER or ERET that is in progress when reset asserts, with no partial CP0 write after reset deasserts.

Structure
REQ-033 SHALL place the state encoding, ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), Status bit positions (IE=0, EXL=1, IM=15:8) and the default VEC_OFFSET in shared package exc_pkg.
REQ-034 SHALL place the timerPend latch and the ip/intReq logic in one sub-module, exc_int_pending.

Verification
REQ-035 SHALL cover this case: excValid, excCode=8, commitPc=0x8000_1000, BD=0, status=0x0000_0001, ebase=0x8000_0000 -> next cycle write13 [6:2]=8, write14data=0x8000_1000, write12data=0x0000_0003, redirectPc=0x8000_0180, flush=1.
REQ-036 SHALL cover this case: BD=1, commitPc=0x8000_2004, code 4, excBadAddr=0x1 -> write14data=0x8000_2000, cause[31]=1, write8=1 with data 0x1.
REQ-037 SHALL cover this case: clockInterrupt pulse, status=0x0000_8001, commitValid held -> ENTER with code 0 and ip[7]=1, then timerPend=0; the same case with status=0x0000_8003 (EXL=1) -> no entry and timerPend stays 1.
REQ-038 SHALL cover this case: excValid, intReq and eretValid in the same cycle -> only the synchronous exception is taken; during ENTER a second excValid is ignored.
REQ-039 SHALL cover this case: eretValid, epc=0x8000_3000, status=0x0000_0003 -> write12data=0x0000_0001 and redirectPc=0x8000_3000; then ready=0 for 3 cycles in ENTER -> outputs held and a single transition on release.
REQ-040 SHALL cover this case: reset asserted mid-ENTER -> all outputs 0 immediately and state IDLE after release.
